alu_pipe_unit: RTL and testbench

Parametrised, two-stage pipelined arithmetic/logic unit with valid/ready handshakes on both sides and an internal accumulator. It is the registered successor of the team's combinational and/or/add/sub result mux. The opcode is carried with each operand pair, so there is no static select and no unreachable result path. It sits between an operand source and a result consumer, and either side may stall.

---
 rtl/alu_pipe_pkg.sv | 18 +
 rtl/alu_pipe_core.sv | 63 ++++++
 rtl/alu_pipe_unit.sv | 108 ++++++++++
 tb/tb_alu_pipe_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode definitions for the pipelined ALU.
// Result bundles are declared in the using module so they can follow its WIDTH.
package alu_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_ADD     = 3'd2,
        OP_SUB     = 3'd3,
        OP_COMBO   = 3'd4,
        OP_ACC     = 3'd5,
        OP_ACC_CLR = 3'd6,
        OP_RSVD    = 3'd7
    } op_e;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational datapath: computes one result from op/a/b and the current acc.
// Accumulator write-back is requested here but committed by the caller.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic [WIDTH-1:0] acc_next,
    output logic             acc_we
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH-1:0] combo;

    // The extra MSB of the widened difference is the unsigned borrow.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign acc_sum = {1'b0, acc} + {1'b0, a};
    assign combo   = sum[WIDTH-1:0] + diff[WIDTH-1:0];

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        err      = 1'b0;
        acc_next = acc;
        acc_we   = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_COMBO: result = combo;
            OP_ACC: begin
                result   = acc_sum[WIDTH-1:0];
                carry    = acc_sum[WIDTH];
                acc_next = acc_sum[WIDTH-1:0];
                acc_we   = 1'b1;
            end
            OP_ACC_CLR: begin
                result   = acc;
                acc_next = '0;
                acc_we   = 1'b1;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe_unit.sv
// Two-stage pipelined ALU with valid/ready on both sides and an accumulator.
// Stage 1 holds operands, stage 2 holds the finished result bundle.
module alu_pipe_unit
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             err;
    } res_t;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    res_t             s2;
    logic [WIDTH-1:0] acc;

    logic             en1;
    logic             en2;
    logic [WIDTH-1:0] c_result;
    logic             c_carry;
    logic             c_err;
    logic [WIDTH-1:0] acc_next;
    logic             acc_we;

    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op),
        .a        (s1_a),
        .b        (s1_b),
        .acc      (acc),
        .result   (c_result),
        .carry    (c_carry),
        .err      (c_err),
        .acc_next (acc_next),
        .acc_we   (acc_we)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_e'(in_op);
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2 <= '{result: c_result,
                        carry:  c_carry,
                        zero:   (c_result == '0),
                        err:    c_err};
            end
        end
    end

    // Commit only as the beat leaves stage 1, so chained ACC beats see it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en2 && s1_valid && acc_we) begin
            acc <= acc_next;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2.result;
    assign out_carry  = s2.carry;
    assign out_zero   = s2.zero;
    assign out_err    = s2.err;

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Self-checking bench for alu_pipe_unit: directed scenarios plus random
// traffic, scored against an in-order queue of expected result bundles.
module tb_alu_pipe_unit;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_zero;
    logic         out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int res;
        bit c;
        bit z;
        bit e;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   macc = 0;

    always #5 clk = ~clk;

    alu_pipe_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, applied in acceptance order.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t r;
        int   s;
        r.res = 0;
        r.c   = 0;
        r.e   = 0;
        case (op)
            0: r.res = a & b;
            1: r.res = a | b;
            2: begin s = a + b; r.res = s % M; r.c = (s >= M); end
            3: begin r.res = (a - b + M) % M; r.c = (a < b); end
            4: r.res = ((a + b) + (a - b) + 2 * M) % M;
            5: begin
                s = macc + a;
                macc = s % M;
                r.res = macc;
                r.c = (s >= M);
            end
            6: begin r.res = macc; macc = 0; end
            default: r.e = 1;
        endcase
        r.z = (r.res == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            macc = 0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q[0];
                    check("result", out_result, e.res);
                    check("carry", out_carry, e.c);
                    check("zero", out_zero, e.z);
                    check("err", out_err, e.e);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(int'(in_op), int'(in_a), int'(in_b)));
        end
    end

    task automatic send(input int op, input int a, input int b,
                        input bit relieve);
        int n = 0;
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_a     = W'(a);
        in_b     = W'(b);
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (relieve) out_ready = 1'b1;
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_carry", out_carry, 0);
        check("rst_zero", out_zero, 0);
        check("rst_err", out_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency of a single beat
        send(2, 3, 4, 0);
        check("lat_edge1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2", out_valid, 1);
        drain();

        // Streaming, one beat per cycle
        send(0, 'hF0, 'h3C, 0);
        send(1, 'hF0, 'h3C, 0);
        check("b2b_1", out_valid, 1);
        send(2, 'hFF, 'h02, 0);
        check("b2b_2", out_valid, 1);
        send(3, 'h01, 'h02, 0);
        check("b2b_3", out_valid, 1);
        drain();

        send(4, 'h05, 'h03, 0);
        send(4, 'h80, 'h00, 0);
        drain();

        // Accumulator chain and wrap
        send(5, 'h10, 'hAA, 0);
        send(5, 'h20, 'h55, 0);
        send(6, 'h00, 'h00, 0);
        send(5, 'h01, 'h00, 0);
        send(6, 'h00, 'h00, 0);
        send(5, 'hFF, 'h00, 0);
        send(5, 'h01, 'h00, 0);
        drain();

        // Backpressure with both stages full
        out_ready = 1'b0;
        send(2, 'h11, 'h22, 0);
        send(3, 'h40, 'h41, 0);
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_a     = 8'h0F;
        in_b     = 8'hA0;
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        send(1, 'h0F, 'hA0, 0);
        send(5, 'h07, 'h00, 0);
        drain();

        // Reserved op leaves acc alone
        send(7, 'h12, 'h34, 0);
        send(5, 'h22, 'h00, 0);
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        send(5, 'h33, 'h00, 0);
        send(2, 'h01, 'h01, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(5, 'h05, 'h00, 0);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send($urandom_range(0, 7), $urandom_range(0, M - 1),
                 $urandom_range(0, M - 1), 1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
